// File: rtl/wave_mem_arbiter_if.sv
// Bundle between voice requesters, the wave memory and wave_mem_arbiter.
// The arbiter uses the slave modport; the voice/memory side uses master.
interface wave_mem_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] addr_a;
  logic [NUM_REQ*ADDR_W-1:0] addr_b;
  logic [NUM_REQ-1:0]        gnt;
  logic                      mem_en;
  logic [ADDR_W-1:0]         mem_addr_a;
  logic [ADDR_W-1:0]         mem_addr_b;
  logic [DATA_W-1:0]         mem_data_a;
  logic [DATA_W-1:0]         mem_data_b;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data_a;
  logic [DATA_W-1:0]         rsp_data_b;

  modport master (
    output req, addr_a, addr_b, mem_data_a, mem_data_b,
    input  gnt, mem_en, mem_addr_a, mem_addr_b, rsp_valid, rsp_data_a, rsp_data_b
  );

  modport slave (
    input  req, addr_a, addr_b, mem_data_a, mem_data_b,
    output gnt, mem_en, mem_addr_a, mem_addr_b, rsp_valid, rsp_data_a, rsp_data_b
  );
endinterface

// File: rtl/wave_mem_arbiter.sv
// Round-robin share of one dual-port wave memory read path among NUM_REQ voices.
// Optional macro WAVE_ARB_FIXED_PRIO0_EN: requester 0 always wins and never moves the pointer.
module wave_mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  wave_mem_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   ptr_d;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] gnt_d;
  logic               mem_en_q;
  logic               mem_en_d;
  logic [ADDR_W-1:0]  mem_addr_a_q;
  logic [ADDR_W-1:0]  mem_addr_a_d;
  logic [ADDR_W-1:0]  mem_addr_b_q;
  logic [ADDR_W-1:0]  mem_addr_b_d;

  // Each tag stage is {valid, originating requester one-hot}.
  logic [MEM_LAT-1:0][NUM_REQ:0] tag_q;
  logic [MEM_LAT-1:0][NUM_REQ:0] tag_d;

  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [NUM_REQ-1:0] rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_a_q;
  logic [DATA_W-1:0]  rsp_data_a_d;
  logic [DATA_W-1:0]  rsp_data_b_q;
  logic [DATA_W-1:0]  rsp_data_b_d;

  logic               rr_found_s;
  logic [IDX_W-1:0]   rr_idx_s;
  int                 rr_cand_s;
  logic [IDX_W-1:0]   rr_cand_idx_s;
  logic               rr_hit_s;
  logic               win_vld_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic [ADDR_W-1:0]  sel_addr_a_s;
  logic [ADDR_W-1:0]  sel_addr_b_s;
  logic               tail_vld_s;
  logic [NUM_REQ-1:0] tail_oh_s;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? {IDX_W{1'b0}} : idx + IDX_W'(1);
  endfunction

  // Round-robin search: first set req bit at or above the pointer, wrapping.
  always_comb begin
    rr_found_s    = 1'b0;
    rr_idx_s      = '0;
    rr_cand_s     = 0;
    rr_cand_idx_s = '0;
    rr_hit_s      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rr_cand_s     = int'(ptr_q) + i;
      rr_cand_s     = (rr_cand_s >= NUM_REQ) ? rr_cand_s - NUM_REQ : rr_cand_s;
      rr_cand_idx_s = IDX_W'(rr_cand_s);
      rr_hit_s      = bus.req[rr_cand_idx_s] & ~rr_found_s;
      rr_idx_s      = rr_hit_s ? rr_cand_idx_s : rr_idx_s;
      rr_found_s    = rr_found_s | rr_hit_s;
    end
  end

  // Final winner and pointer advance.
  always_comb begin
    win_vld_s = rr_found_s;
    win_idx_s = rr_idx_s;
    ptr_d     = ptr_q;
`ifdef WAVE_ARB_FIXED_PRIO0_EN
    if (bus.req[0]) begin
      // The audio output voice bypasses the rotation entirely.
      win_vld_s = 1'b1;
      win_idx_s = '0;
      ptr_d     = ptr_q;
    end else if (rr_found_s) begin
      ptr_d = next_ptr(rr_idx_s);
    end else begin
      ptr_d = ptr_q;
    end
`else
    if (rr_found_s) begin
      ptr_d = next_ptr(rr_idx_s);
    end else begin
      ptr_d = ptr_q;
    end
`endif
  end

  // Address mux for the winning requester.
  always_comb begin
    sel_addr_a_s = '0;
    sel_addr_b_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr_a_s = (win_idx_s == IDX_W'(i)) ? bus.addr_a[i*ADDR_W +: ADDR_W] : sel_addr_a_s;
      sel_addr_b_s = (win_idx_s == IDX_W'(i)) ? bus.addr_b[i*ADDR_W +: ADDR_W] : sel_addr_b_s;
    end
  end

  // Next-state for the issue side, tag pipeline and response side.
  always_comb begin
    gnt_d        = win_vld_s ? (ONE_HOT0 << win_idx_s) : {NUM_REQ{1'b0}};
    mem_en_d     = win_vld_s;
    mem_addr_a_d = win_vld_s ? sel_addr_a_s : mem_addr_a_q;
    mem_addr_b_d = win_vld_s ? sel_addr_b_s : mem_addr_b_q;

    tag_d    = tag_q;
    tag_d[0] = {mem_en_q, gnt_q};
    for (int s = 1; s < MEM_LAT; s++) begin
      tag_d[s] = tag_q[s-1];
    end

    tail_vld_s   = tag_q[MEM_LAT-1][NUM_REQ];
    tail_oh_s    = tag_q[MEM_LAT-1][NUM_REQ-1:0];
    rsp_valid_d  = tail_vld_s ? tail_oh_s : {NUM_REQ{1'b0}};
    rsp_data_a_d = tail_vld_s ? bus.mem_data_a : rsp_data_a_q;
    rsp_data_b_d = tail_vld_s ? bus.mem_data_b : rsp_data_b_q;
  end

  // Issue-side registers: pointer, grant and memory address ports.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q        <= '0;
      gnt_q        <= '0;
      mem_en_q     <= 1'b0;
      mem_addr_a_q <= '0;
      mem_addr_b_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      mem_en_q     <= mem_en_d;
      mem_addr_a_q <= mem_addr_a_d;
      mem_addr_b_q <= mem_addr_b_d;
    end
  end

  // Tag pipeline riding alongside the memory latency; reset drops in-flight reads.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  // Response registers: strobe to the originator, data held between responses.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rsp_valid_q  <= '0;
      rsp_data_a_q <= '0;
      rsp_data_b_q <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_a_q <= rsp_data_a_d;
      rsp_data_b_q <= rsp_data_b_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_addr_a = mem_addr_a_q;
  assign bus.mem_addr_b = mem_addr_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data_a = rsp_data_a_q;
  assign bus.rsp_data_b = rsp_data_b_q;
endmodule
